// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter, the two cache fill paths, the D-side
// store path and the main-memory port.
interface mem_arbiter_if;
  logic        i_miss;
  logic [15:0] i_addr;
  logic        d_miss;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_data_in;
  logic        mem_data_valid;
  logic        fill_we;
  logic        fill_sel;
  logic [2:0]  fill_word;
  logic [15:0] fill_data;
  logic        i_done;
  logic        d_done;
  logic        busy;

  modport master (
    input  i_miss, i_addr, d_miss, d_wr, d_addr, d_wdata,
    input  mem_data_in, mem_data_valid,
    output mem_en, mem_wr, mem_addr, mem_wdata,
    output fill_we, fill_sel, fill_word, fill_data,
    output i_done, d_done, busy
  );

  modport slave (
    output i_miss, i_addr, d_miss, d_wr, d_addr, d_wdata,
    output mem_data_in, mem_data_valid,
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    input  fill_we, fill_sel, fill_word, fill_data,
    input  i_done, d_done, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Main-memory arbiter: serialised, non-preemptible block fills for the I/D
// caches plus single-cycle D-side write-through stores.
module mem_arbiter #(
  parameter int MEM_LAT = 4,
  parameter int WORDS   = 8
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.master bus
);

  localparam int WW  = $clog2(WORDS);
  localparam int OFF = WW + 1;
  localparam logic [WW:0]   WORDS_C   = (WW+1)'(WORDS);
  localparam logic [WW-1:0] LAST_C    = WW'(WORDS - 1);
  localparam logic [15:0]   BASE_MASK = ~16'((2 * WORDS) - 1);

  // Returns can never arrive in their own issue cycle, and a block needs at least two words.
  if (MEM_LAT < 1 || WORDS < 2) begin : g_param_check
    $error("mem_arbiter: MEM_LAT must be >= 1 and WORDS >= 2");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [WW:0]   ic_r, ic_s;
  logic [WW-1:0] rc_r, rc_s;
  logic          owner_r, owner_s;
  logic [15:0]   base_r, base_s;
  logic [15:0]   waddr_r, waddr_s;
  logic [15:0]   wdata_r, wdata_s;

  // State, counters and latched grant information.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      ic_r    <= '0;
      rc_r    <= '0;
      owner_r <= 1'b0;
      base_r  <= 16'h0000;
      waddr_r <= 16'h0000;
      wdata_r <= 16'h0000;
    end else begin
      state_r <= state_s;
      ic_r    <= ic_s;
      rc_r    <= rc_s;
      owner_r <= owner_s;
      base_r  <= base_s;
      waddr_r <= waddr_s;
      wdata_r <= wdata_s;
    end
  end

  // Arbitration in IDLE (d_miss > d_wr > i_miss) and fill progress tracking.
  always_comb begin
    state_s = state_r;
    ic_s    = ic_r;
    rc_s    = rc_r;
    owner_s = owner_r;
    base_s  = base_r;
    waddr_s = waddr_r;
    wdata_s = wdata_r;
    case (state_r)
      IDLE: begin
        ic_s = '0;
        rc_s = '0;
        if (bus.d_miss) begin
          state_s = FILL;
          owner_s = 1'b1;
          base_s  = bus.d_addr & BASE_MASK;
        end else if (bus.d_wr) begin
          state_s = WRITE;
          waddr_s = bus.d_addr;
          wdata_s = bus.d_wdata;
        end else if (bus.i_miss) begin
          state_s = FILL;
          owner_s = 1'b0;
          base_s  = bus.i_addr & BASE_MASK;
        end else begin
          state_s = IDLE;
        end
      end
      FILL: begin
        if (ic_r < WORDS_C) begin
          ic_s = ic_r + {{WW{1'b0}}, 1'b1};
        end else begin
          ic_s = ic_r;
        end
        if (bus.mem_data_valid && (rc_r == LAST_C)) begin
          state_s = IDLE;
          ic_s    = '0;
          rc_s    = '0;
        end else if (bus.mem_data_valid) begin
          rc_s = rc_r + {{(WW-1){1'b0}}, 1'b1};
        end else begin
          rc_s = rc_r;
        end
      end
      WRITE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        ic_s    = '0;
        rc_s    = '0;
      end
    endcase
  end

  // Memory strobes decode from registered state; fill/done follow the return in the same cycle.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = 16'h0000;
    bus.mem_wdata = 16'h0000;
    bus.fill_we   = 1'b0;
    bus.fill_sel  = 1'b0;
    bus.fill_word = 3'd0;
    bus.fill_data = 16'h0000;
    bus.i_done    = 1'b0;
    bus.d_done    = 1'b0;
    bus.busy      = 1'b0;
    case (state_r)
      IDLE: begin
        bus.busy = 1'b0;
      end
      FILL: begin
        bus.busy = 1'b1;
        if (ic_r < WORDS_C) begin
          bus.mem_en   = 1'b1;
          bus.mem_addr = base_r | {{(16-OFF){1'b0}}, ic_r[WW-1:0], 1'b0};
        end else begin
          bus.mem_en = 1'b0;
        end
        if (bus.mem_data_valid) begin
          bus.fill_we   = 1'b1;
          bus.fill_sel  = owner_r;
          bus.fill_word = 3'(rc_r);
          bus.fill_data = bus.mem_data_in;
          bus.i_done    = (rc_r == LAST_C) && !owner_r;
          bus.d_done    = (rc_r == LAST_C) && owner_r;
        end else begin
          bus.fill_we = 1'b0;
        end
      end
      WRITE: begin
        bus.busy      = 1'b1;
        bus.mem_en    = 1'b1;
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = waddr_r;
        bus.mem_wdata = wdata_r;
        bus.d_done    = 1'b1;
      end
      default: begin
        bus.busy = 1'b0;
      end
    endcase
  end

endmodule
